// File: rtl/cordic_pkg.sv
// rtl/cordic_pkg.sv - shared Q16.16 constants and FSM state type for the CORDIC argument reducer.
package cordic_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int FRAC_DEF  = 16;
    localparam int STEPS_DEF = 14;

    // Q16.16 constants, only meaningful for FRAC = 16
    localparam logic [31:0] PI_Q16          = 32'd205887;
    localparam logic [31:0] HALF_PI_Q16     = 32'd102944;
    localparam logic [31:0] TWO_PI_Q16      = 32'd411775;
    localparam logic [31:0] CORDIC_INV_GAIN = 32'd39797;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REDUCE = 2'd1,
        S_FOLD   = 2'd2,
        S_OUT    = 2'd3
    } red_state_t;

endpackage

// File: rtl/cordic_mod2pi_step.sv
// rtl/cordic_mod2pi_step.sv - one restoring mod-2pi step: subtract TWO_PI<<k from a when it fits.
module cordic_mod2pi_step
    import cordic_pkg::*;
#(
    parameter int AW    = 33,
    parameter int STEPS = STEPS_DEF,
    parameter int KW    = $clog2(STEPS)
) (
    input  logic [AW-1:0] a,
    input  logic [KW-1:0] k,
    output logic [AW-1:0] a_next
);

    localparam int XW = AW + STEPS;

    logic [XW-1:0]    a_ext;
    logic [XW-1:0]    sub;
    logic [XW-1:0]    diff;
    logic [XW-AW-1:0] unused_diff_hi;

    // Extended width keeps TWO_PI<<k exact for every k; the difference is only
    // taken when a >= sub, so it always fits back into AW bits.
    assign a_ext          = {{STEPS{1'b0}}, a};
    assign sub            = {{(XW-32){1'b0}}, TWO_PI_Q16} << k;
    assign diff           = a_ext - sub;
    assign a_next         = (a_ext >= sub) ? diff[AW-1:0] : a;
    assign unused_diff_hi = diff[XW-1:AW];

endmodule

// File: rtl/cordic_arg_reducer.sv
// rtl/cordic_arg_reducer.sv - reduces a Q16.16 angle to [-pi/2,pi/2] plus flip flag for the CORDIC rotator.
// Optional macro CORDIC_GAIN_PRECOMP_EN: x0 starts at the inverse CORDIC gain instead of 1.0.
module cordic_arg_reducer
    import cordic_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int FRAC  = FRAC_DEF,
    parameter int STEPS = STEPS_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_angle,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x0,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] z0,
    output logic             out_flip
);

    localparam int AW = WIDTH + 1;
    localparam int KW = $clog2(STEPS);

    localparam logic signed [WIDTH-1:0] PI_S      = $signed(WIDTH'(PI_Q16));
    localparam logic signed [WIDTH-1:0] HALF_PI_S = $signed(WIDTH'(HALF_PI_Q16));
    localparam logic signed [WIDTH-1:0] TWO_PI_S  = $signed(WIDTH'(TWO_PI_Q16));

`ifdef CORDIC_GAIN_PRECOMP_EN
    localparam logic [WIDTH-1:0] X_INIT = WIDTH'(CORDIC_INV_GAIN);
`else
    localparam logic [WIDTH-1:0] X_INIT = WIDTH'(1) << FRAC;
`endif

    red_state_t state;
    logic          s;
    logic [AW-1:0] a;
    logic [KW-1:0] k;
    logic [AW-1:0] a_next;

    logic signed [AW-1:0] in_ext;
    logic        [AW-1:0] in_abs;

    logic signed [WIDTH-1:0] r0;
    logic signed [WIDTH-1:0] r1;
    logic signed [WIDTH-1:0] z_fold;
    logic                    flip_fold;

    cordic_mod2pi_step #(
        .AW    (AW),
        .STEPS (STEPS),
        .KW    (KW)
    ) u_step (
        .a      (a),
        .k      (k),
        .a_next (a_next)
    );

    // One extra bit so |-2^(WIDTH-1)| is representable exactly.
    always_comb begin
        in_ext = {in_angle[WIDTH-1], in_angle};
        in_abs = in_angle[WIDTH-1] ? AW'(-in_ext) : AW'(in_ext);
    end

    // After reduction a < TWO_PI, so its low WIDTH bits carry the whole value.
    always_comb begin
        r0 = s ? -$signed(a[WIDTH-1:0]) : $signed(a[WIDTH-1:0]);
        r1 = r0;
        if (r0 > PI_S) begin
            r1 = r0 - TWO_PI_S;
        end else if (r0 < -PI_S) begin
            r1 = r0 + TWO_PI_S;
        end
        z_fold    = r1;
        flip_fold = 1'b0;
        if (r1 > HALF_PI_S) begin
            z_fold    = r1 - PI_S;
            flip_fold = 1'b1;
        end else if (r1 < -HALF_PI_S) begin
            z_fold    = r1 + PI_S;
            flip_fold = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x0        <= '0;
            y0        <= '0;
            z0        <= '0;
            out_flip  <= 1'b0;
            s         <= 1'b0;
            a         <= '0;
            k         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        s        <= in_angle[WIDTH-1];
                        a        <= in_abs;
                        k        <= KW'(STEPS - 1);
                        in_ready <= 1'b0;
                        state    <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    a <= a_next;
                    if (k == '0) begin
                        state <= S_FOLD;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                S_FOLD: begin
                    z0        <= z_fold;
                    out_flip  <= flip_fold;
                    x0        <= X_INIT;
                    y0        <= '0;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_arg_reducer.sv
// tb/tb_cordic_arg_reducer.sv - directed-vector bench for cordic_arg_reducer.
module tb_cordic_arg_reducer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_angle;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] x0;
    logic [31:0] y0;
    logic [31:0] z0;
    logic        out_flip;

    int checks;
    int errors;

`ifdef CORDIC_GAIN_PRECOMP_EN
    localparam logic [31:0] X_EXP = 32'd39797;
`else
    localparam logic [31:0] X_EXP = 32'd65536;
`endif

    cordic_arg_reducer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_angle  (in_angle),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x0        (x0),
        .y0        (y0),
        .z0        (z0),
        .out_flip  (out_flip)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Presents one angle and waits for out_valid. lat counts rising edges from
    // the accept edge (1) through the edge that raises out_valid.
    task automatic launch(input logic [31:0] angle, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = angle;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_vec(input string tag, input logic [31:0] angle,
                           input logic [31:0] exp_z, input logic exp_flip);
        int lat;
        out_ready = 1'b1;
        launch(angle, lat);
        check({tag, ".lat"}, lat, 32'd16);
        check({tag, ".z0"}, z0, exp_z);
        check({tag, ".flip"}, {31'd0, out_flip}, {31'd0, exp_flip});
        check({tag, ".x0"}, x0, X_EXP);
        check({tag, ".y0"}, y0, 32'd0);
        @(posedge clk);
        #1;
        check({tag, ".vld_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".rdy_back"}, {31'd0, in_ready}, 32'd1);
    endtask

    typedef struct {
        string       tag;
        logic [31:0] angle;
        logic [31:0] z;
        logic        flip;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int lat;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_angle  = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.x0", x0, 32'd0);
        check("rst.z0", z0, 32'd0);
        check("rst.flip", {31'd0, out_flip}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vecs.push_back('{"half_pi_m1", 32'd102943,   32'd102943,  1'b0});
        vecs.push_back('{"six_pi_q",   32'd1286797,  32'd51472,   1'b0});
        vecs.push_back('{"p3q",        32'd154415,  -32'sd51472,  1'b1});
        vecs.push_back('{"n3q",       -32'sd154415,  32'd51472,   1'b1});
        vecs.push_back('{"pi",         32'd205887,   32'd0,       1'b1});
        vecs.push_back('{"neg_pi",    -32'sd205887,  32'd0,       1'b1});
        vecs.push_back('{"half_pi",    32'd102944,   32'd102944,  1'b0});
        vecs.push_back('{"zero",       32'd0,        32'd0,       1'b0});
        vecs.push_back('{"p300k",      32'd300000,   32'd94112,   1'b1});
        vecs.push_back('{"n300k",     -32'sd300000, -32'sd94112,  1'b1});
        vecs.push_back('{"min_int",    32'h80000000, -32'sd77023, 1'b0});
        vecs.push_back('{"max_int",    32'h7fffffff, 32'd77022,   1'b0});
        foreach (vecs[i]) run_vec(vecs[i].tag, vecs[i].angle, vecs[i].z, vecs[i].flip);

        // Backpressure: result must hold while a second request is offered.
        out_ready = 1'b0;
        launch(32'd154415, lat);
        check("stall.lat", lat, 32'd16);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_angle = 32'd1000;
            @(posedge clk);
            #1;
            check("stall.valid", {31'd0, out_valid}, 32'd1);
            check("stall.in_ready", {31'd0, in_ready}, 32'd0);
            check("stall.z0", z0, -32'sd51472);
            check("stall.flip", {31'd0, out_flip}, 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall.release_valid", {31'd0, out_valid}, 32'd0);
        check("stall.release_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("stall.still_idle", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of reduction aborts without producing a result.
        @(negedge clk);
        in_valid = 1'b1;
        in_angle = 32'd300000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort.out_valid", {31'd0, out_valid}, 32'd0);
        check("abort.in_ready", {31'd0, in_ready}, 32'd1);
        check("abort.z0", z0, 32'd0);
        check("abort.x0", x0, 32'd0);
        check("abort.flip", {31'd0, out_flip}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("abort.no_output", {31'd0, out_valid}, 32'd0);

        run_vec("after_abort", 32'd154415, -32'sd51472, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
